mult_fu_pipe: RTL

//  Pipelined 64-bit integer multiply unit; consumes the per-FU enable, dest tag, bmask and bs_ptr issued by the

---
 rtl/mult_fu_pipe_pkg.sv | 32 +++
 rtl/mult_fu_pipe_stage.sv | 23 ++
 rtl/mult_fu_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/mult_fu_pipe_pkg.sv
// Shared types for the pipelined multiply unit: register/branch tag widths,
// the per-stage pipeline record and the branch-mask resolve helper.
package mult_fu_pipe_pkg;

  localparam int MULT_DATA_W = 64;
  localparam int MULT_STAGES = 4;
  localparam int PHYS_REG_W  = 6;
  localparam int B_MASK_W    = 4;
  localparam int BS_PTR_W    = 2;

  typedef logic [PHYS_REG_W-1:0] PHYS_REG;
  typedef logic [B_MASK_W-1:0]   B_MASK;
  typedef logic [BS_PTR_W-1:0]   BS_PTR;

  typedef struct packed {
    logic                   valid;
    PHYS_REG                tag;
    B_MASK                  bmask;
    logic [MULT_DATA_W-1:0] prod;
    logic [MULT_DATA_W-1:0] mcand;
    logic [MULT_DATA_W-1:0] mplier;
  } MULT_STAGE_t;

  // A correctly predicted branch frees its slot bit in every dependent mask.
  function automatic B_MASK resolve_bmask(B_MASK mask, logic resolved, logic wrong, BS_PTR ptr);
    B_MASK m;
    m = mask;
    if (resolved && !wrong) m[ptr] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/mult_fu_pipe_stage.sv
// One partial-product step: adds (mcand * digit) << (CHUNK_IDX*chunk) into
// the running product, modulo 2^DATA_W.
module mult_stage
  import mult_fu_pipe_pkg::*;
#(
  parameter int DATA_W    = MULT_DATA_W,
  parameter int STAGES    = MULT_STAGES,
  parameter int CHUNK_IDX = 0
) (
  input  logic [DATA_W-1:0]        prod_in,
  input  logic [DATA_W-1:0]        mcand,
  input  logic [DATA_W/STAGES-1:0] digit,
  output logic [DATA_W-1:0]        prod_out
);

  localparam int CHUNK = DATA_W / STAGES;

  logic [DATA_W-1:0] partial;

  assign partial  = mcand * {{(DATA_W-CHUNK){1'b0}}, digit};
  assign prod_out = prod_in + (partial << (CHUNK_IDX * CHUNK));

endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined multiply functional unit: issue capture, bubble-collapsing advance
// chain, branch-mask update/squash, CDB req/gnt handshake and issue back-pressure.
module mult_fu_pipe
  import mult_fu_pipe_pkg::*;
#(
  parameter int STAGES = MULT_STAGES,
  parameter int DATA_W = MULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fu_en,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  PHYS_REG           tag_dest,
  input  B_MASK             bmask,
  input  logic              br_resolved,
  input  logic              br_wrong,
  input  BS_PTR             br_bs_ptr,
  input  logic              cdb_gnt,
  output logic              fub_busy,
  output logic              cdb_req,
  output PHYS_REG           cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output B_MASK             cdb_bmask
);

  localparam int LAST  = STAGES - 1;
  localparam int CHUNK = DATA_W / STAGES;
  localparam int OCC_W = $clog2(STAGES + 2);

  MULT_STAGE_t       stg_reg  [STAGES];
  MULT_STAGE_t       stg_next [STAGES];
  MULT_STAGE_t       src      [STAGES];
  logic [DATA_W-1:0] step_prod[STAGES];
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] load;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  demand;
  logic              br_kill;
  logic              retire;

  assign br_kill = br_resolved && br_wrong;

  // src[k] is the record stage k captures when it loads; stage 0 loads from issue.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_issue
      assign src[gi] = '{valid: fu_en, tag: tag_dest, bmask: bmask,
                         prod: '0, mcand: opa, mplier: opb};
    end else begin : g_chain
      assign src[gi] = stg_reg[gi-1];
    end

    mult_stage #(
      .DATA_W   (DATA_W),
      .STAGES   (STAGES),
      .CHUNK_IDX(gi)
    ) u_step (
      .prod_in (src[gi].prod),
      .mcand   (src[gi].mcand),
      .digit   (src[gi].mplier[gi*CHUNK +: CHUNK]),
      .prod_out(step_prod[gi])
    );
  end

  // A stage loads when it is empty or its occupant moves on; this lets bubbles collapse.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      kill[k] = br_kill && stg_reg[k].valid && stg_reg[k].bmask[br_bs_ptr];
    end
    load[LAST] = !stg_reg[LAST].valid || cdb_gnt;
    for (int k = LAST - 1; k >= 0; k--) begin
      load[k] = !stg_reg[k].valid || load[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        stg_next[k]       = src[k];
        stg_next[k].valid = src[k].valid && !(br_kill && src[k].bmask[br_bs_ptr]);
        stg_next[k].bmask = resolve_bmask(src[k].bmask, br_resolved, br_wrong, br_bs_ptr);
        stg_next[k].prod  = step_prod[k];
      end else begin
        stg_next[k]       = stg_reg[k];
        stg_next[k].valid = stg_reg[k].valid && !kill[k];
        stg_next[k].bmask = resolve_bmask(stg_reg[k].bmask, br_resolved, br_wrong, br_bs_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (!reset_n) begin
        stg_reg[k].valid <= 1'b0;
      end else begin
        stg_reg[k] <= stg_next[k];
      end
    end
  end

  assign cdb_req   = stg_reg[LAST].valid && !kill[LAST];
  assign retire    = cdb_req && cdb_gnt;
  assign cdb_tag   = stg_reg[LAST].tag;
  assign cdb_value = stg_reg[LAST].prod;
  assign cdb_bmask = resolve_bmask(stg_reg[LAST].bmask, br_resolved, br_wrong, br_bs_ptr);

  // Squashes are not credited, so busy may linger one cycle longer than needed.
  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(stg_reg[k].valid);
    end
    demand   = occ + OCC_W'(fu_en) - OCC_W'(retire);
    fub_busy = demand >= OCC_W'(STAGES);
  end

  a_issue_accepted: assert property (@(posedge clk) disable iff (!reset_n) fu_en |-> load[0]);

endmodule
